// File: rtl/frame_serializer_pkg.sv
// Shared types and helpers for the frame serializer: FSM state encoding and counter sizing.
package frame_serializer_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StSync  = 2'd1,
      StShift = 2'd2,
      StGap   = 2'd3
   } state_e;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frame_serializer_word_hold_reg.sv
// Single-entry holding register: captures a word on load, releases it on drain.
module word_hold_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             drain_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             full_q, full_d;

   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (drain_i) begin
         full_d = 1'b0;
      end else if (load_i) begin
         full_d = 1'b1;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign data_o = data_q;
   assign full_o = full_q;

endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial framer: one-cycle sync pulse, WIDTH data bits MSB-first, then an idle gap.
module frame_serializer
   import frame_serializer_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned GAP        = 2,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input  logic             Clock,
   input  logic             R,
   input  logic [WIDTH-1:0] Din,
   input  logic             Load,
   output logic             Ready,
   output logic             S,
   output logic             I,
   output logic             Busy,
   output logic             Done
);

   localparam int unsigned    BitW    = cnt_width(WIDTH);
   localparam int unsigned    GapW    = cnt_width(GAP + 1);
   localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);
   localparam logic [GapW-1:0] GapLast = GapW'((GAP > 0) ? GAP - 1 : 0);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
   logic             s_q, s_d, i_q, i_d, busy_q, busy_d, done_q, done_d;

   logic             hold_full, drain, accept;
   logic [WIDTH-1:0] hold_data;

   // Ready depends only on hold state, so accept has no combinational loop through Ready.
   assign Ready  = ~hold_full;
   assign accept = Load & ~hold_full & ~R;

   word_hold_reg #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk_i   (Clock),
      .rst_i   (R),
      .load_i  (accept),
      .drain_i (drain),
      .data_i  (Din),
      .data_o  (hold_data),
      .full_o  (hold_full)
   );

   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      drain     = 1'b0;

      case (state_q)
         StIdle: begin
            if (hold_full) state_d = StSync;
         end
         StSync: begin
            state_d   = StShift;
            bit_cnt_d = '0;
         end
         StShift: begin
            sreg_d    = {sreg_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BitLast) begin
               bit_cnt_d = '0;
               gap_cnt_d = '0;
               if (GAP > 0) state_d = StGap;
               else         state_d = hold_full ? StSync : StIdle;
            end
         end
         StGap: begin
            gap_cnt_d = gap_cnt_q + 1'b1;
            if (gap_cnt_q == GapLast) begin
               gap_cnt_d = '0;
               state_d   = hold_full ? StSync : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Every entry into SYNC pulls the queued word into the shifter.
      if (state_d == StSync) begin
         drain  = 1'b1;
         sreg_d = hold_data;
      end
   end

   // Outputs are registered from next-state values so they line up with the state they describe.
   always_comb begin
      s_d    = (state_d == StSync);
      busy_d = (state_d != StIdle);
      done_d = (state_d == StShift) && (bit_cnt_d == BitLast);
      case (state_d)
         StSync:  i_d = 1'b0;
         StShift: i_d = sreg_d[WIDTH-1];
         default: i_d = IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (R) begin
         state_q   <= StIdle;
         sreg_q    <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         s_q       <= 1'b0;
         i_q       <= IDLE_LEVEL;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         s_q       <= s_d;
         i_q       <= i_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign S    = s_q;
   assign I    = i_q;
   assign Busy = busy_q;
   assign Done = done_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Scoreboard bench for frame_serializer: an 8-bit/gap-2 instance and a 4-bit/gap-0 instance.
module tb_frame_serializer;

   localparam int Gap8 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       r;
   logic [7:0] din8;
   logic       load8, ready8, s8, i8, busy8, done8;
   logic [3:0] din4;
   logic       load4, ready4, s4, i4, busy4, done4;

   frame_serializer #(
      .WIDTH      (8),
      .GAP        (2),
      .IDLE_LEVEL (1'b0)
   ) u_dut8 (
      .Clock (clk),
      .R     (r),
      .Din   (din8),
      .Load  (load8),
      .Ready (ready8),
      .S     (s8),
      .I     (i8),
      .Busy  (busy8),
      .Done  (done8)
   );

   frame_serializer #(
      .WIDTH      (4),
      .GAP        (0),
      .IDLE_LEVEL (1'b0)
   ) u_dut4 (
      .Clock (clk),
      .R     (r),
      .Din   (din4),
      .Load  (load4),
      .Ready (ready4),
      .S     (s4),
      .I     (i4),
      .Busy  (busy4),
      .Done  (done4)
   );

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   logic exp_q[$];
   int   s_times[$];
   bit   mon_en = 1'b0;
   bit   in_frame = 1'b0;
   int   mon_bits = 0;
   int   gap_left = 0;
   logic exp_bit;

   bit   log4_en = 1'b0;
   int   n4 = 0;
   logic s4_log[64];
   logic i4_log[64];
   logic d4_log[64];
   logic b4_log[64];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor for the 8-bit instance: pops one expected bit per data cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (s8) begin
            check_eq("s_outside_frame", {31'd0, in_frame}, 32'd0);
            check_eq("s_after_full_gap", gap_left, 0);
            check_eq("s_has_word", exp_q.size() >= 8, 1);
            check_eq("sync_i", i8, 0);
            check_eq("sync_busy", busy8, 1);
            check_eq("sync_done", done8, 0);
            s_times.push_back(cyc);
            in_frame = 1'b1;
            mon_bits = 0;
            gap_left = 0;
         end else if (in_frame) begin
            check_eq("sb_nonempty", exp_q.size() != 0, 1);
            exp_bit = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b0;
            check_eq("bit_i", i8, exp_bit);
            check_eq("bit_done", done8, mon_bits == 7);
            check_eq("bit_busy", busy8, 1);
            mon_bits++;
            if (mon_bits == 8) begin
               in_frame = 1'b0;
               gap_left = Gap8;
            end
         end else if (gap_left > 0) begin
            check_eq("gap_i", i8, 0);
            check_eq("gap_done", done8, 0);
            check_eq("gap_busy", busy8, 1);
            gap_left--;
         end else begin
            check_eq("idle_i", i8, 0);
            check_eq("idle_done", done8, 0);
            check_eq("idle_busy", busy8, 0);
         end
      end
   end

   always @(negedge clk) begin
      if (log4_en && n4 < 64) begin
         s4_log[n4] = s4;
         i4_log[n4] = i4;
         d4_log[n4] = done4;
         b4_log[n4] = busy4;
         n4++;
      end
   end

   task automatic send8(input logic [7:0] w);
      int t;
      t = 0;
      while (ready8 !== 1'b1 && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      check_eq("send_ready_wait", t < 200, 1);
      load8 = 1'b1;
      din8  = w;
      for (int k = 7; k >= 0; k--) exp_q.push_back(w[k]);
      @(posedge clk);
      #1;
      load8 = 1'b0;
      din8  = ~w;
   endtask

   task automatic wait_idle8(input string tag);
      int t;
      t = 0;
      while (!(exp_q.size() == 0 && !in_frame && gap_left == 0 && busy8 === 1'b0 &&
               ready8 === 1'b1) && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      check_eq(tag, t < 300, 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int         t;
      int         f;
      int         g;
      logic [3:0] w0;
      logic [3:0] w1;
      logic       exp_s, exp_i, exp_d, exp_b;

      // Reset with Load held high: nothing may be accepted.
      r     = 1'b1;
      load8 = 1'b1;
      din8  = 8'hFF;
      load4 = 1'b1;
      din4  = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_s", s8, 0);
      check_eq("rst_i", i8, 0);
      check_eq("rst_busy", busy8, 0);
      check_eq("rst_done", done8, 0);
      check_eq("rst_ready", ready8, 1);
      check_eq("rst_ready4", ready4, 1);
      r     = 1'b0;
      load8 = 1'b0;
      load4 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_eq("rst_no_frame_busy", busy8, 0);
      check_eq("rst_no_frame_s", s8, 0);
      check_eq("rst_no_frame_busy4", busy4, 0);
      mon_en = 1'b1;

      // Single frame.
      s_times.delete();
      send8(8'hA5);
      wait_idle8("single_idle");
      check_eq("single_s_count", s_times.size(), 1);

      // Back-to-back frames.
      s_times.delete();
      send8(8'h0F);
      send8(8'hF0);
      wait_idle8("b2b_idle");
      check_eq("b2b_s_count", s_times.size(), 2);
      if (s_times.size() == 2) check_eq("b2b_period", s_times[1] - s_times[0], 11);

      // Backpressure: a third word while the hold register is full is dropped.
      s_times.delete();
      send8(8'h11);
      send8(8'h22);
      check_eq("bp_ready", ready8, 0);
      load8 = 1'b1;
      din8  = 8'h33;
      @(posedge clk);
      #1;
      load8 = 1'b0;
      check_eq("bp_ready_still", ready8, 0);
      wait_idle8("bp_idle");
      check_eq("bp_s_count", s_times.size(), 2);

      // Mid-frame reset with a queued word.
      s_times.delete();
      send8(8'hC3);
      send8(8'h5A);
      t = 0;
      while (!(in_frame && mon_bits == 4) && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      check_eq("mr_reach_bit4", t < 100, 1);
      check_eq("mr_hold_full", ready8, 0);
      r      = 1'b1;
      mon_en = 1'b0;
      @(posedge clk);
      #1;
      r = 1'b0;
      check_eq("mr_s", s8, 0);
      check_eq("mr_i", i8, 0);
      check_eq("mr_busy", busy8, 0);
      check_eq("mr_done", done8, 0);
      check_eq("mr_ready", ready8, 1);
      exp_q.delete();
      in_frame = 1'b0;
      gap_left = 0;
      mon_bits = 0;
      mon_en   = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check_eq("mr_no_resend", s_times.size(), 1);
      mon_en = 1'b0;

      // WIDTH=4, GAP=0: two queued words, S pulses 5 cycles apart.
      w0      = 4'h9;
      w1      = 4'h6;
      log4_en = 1'b1;
      load4   = 1'b1;
      din4    = w0;
      @(posedge clk);
      #1;
      load4 = 1'b0;
      din4  = 4'h0;
      t = 0;
      while (ready4 !== 1'b1 && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      check_eq("c4_ready_wait", t < 50, 1);
      load4 = 1'b1;
      din4  = w1;
      @(posedge clk);
      #1;
      load4 = 1'b0;
      din4  = 4'h0;
      repeat (16) @(posedge clk);
      #1;
      log4_en = 1'b0;

      f = -1;
      for (int k = 0; k < n4; k++) if (s4_log[k] === 1'b1 && f < 0) f = k;
      check_eq("c4_s_found", f >= 0, 1);
      check_eq("c4_log_len", (f + 10) < n4, 1);
      if (f >= 0 && (f + 10) < n4) begin
         g = -1;
         for (int k = f + 1; k < n4; k++) if (s4_log[k] === 1'b1 && g < 0) g = k;
         check_eq("c4_s_period", g - f, 5);
         for (int c = 1; c <= 10; c++) begin
            exp_s = (c == 5);
            if (c >= 1 && c <= 4)      exp_i = w0[4-c];
            else if (c >= 6 && c <= 9) exp_i = w1[9-c];
            else                       exp_i = 1'b0;
            exp_d = (c == 4) || (c == 9);
            exp_b = (c != 10);
            check_eq("c4_s", s4_log[f+c], exp_s);
            check_eq("c4_i", i4_log[f+c], exp_i);
            check_eq("c4_done", d4_log[f+c], exp_d);
            check_eq("c4_busy", b4_log[f+c], exp_b);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
